stage_b: RTL and testbench
==========================

# stage_B

Second stage of the example byte pipeline, directly downstream of the `+1` stage. It accepts bytes over the DIR/ack_prev handshake and buffers them in a small FIFO. Each byte is doubled with saturation and offered to the next stage over the DOR/ack_from_next handshake. The FIFO decouples upstream acceptance from downstream stalls, so the upstream stage is only stalled when the buffer is full.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `DIR`  in  1  upstream data ready; `data_in` is valid while high.
- `data_in`  in  8  upstream byte.
- `ack_prev`  out  1  one-cycle accept pulse to upstream.
- `DOR`  out  1  `data_out` valid for the next stage.
- `data_out`  out  8  processed byte; 0 whenever DOR is low.
- `ack_from_next`  in  1  downstream accept pulse.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.

## Operation
- Reset values: `ack_prev`=0, `DOR`=0, `data_out`=0, `count`=0. The FIFO pointers clear, and the output FSM goes to IDLE.
- **Input accept.** At an edge, accept when DIR=1, `ack_prev`=0, and (count<DEPTH or a pop occurs at the same edge).
  - On accept, push `data_in` and set `ack_prev`<=1.
  - Otherwise `ack_prev`<=0.
  - Because acceptance requires `ack_prev`=0, two accepts are never back-to-back. This covers the cycle in which upstream still shows DIR=1 after the ack.
- **Full.** While full with no pop, no ack is issued. Upstream holds DIR and data, and the byte is accepted at the first edge with space.
- **Transform.** `data_out` = min(2*d, 255). Compute in 9 bits: if bit 8 is set, output 8'hFF, else bits [7:0].
- **Output FSM, two states (shared encoding: IDLE=0, WAITING_ACK=1).**
  - IDLE: if count>0 (pre-edge value), pop the head, load the transformed value into `data_out`, set `DOR`<=1, and go to WAITING_ACK.
  - IDLE with an empty FIFO: stay in IDLE with `DOR`=0 and `data_out`=0.
  - WAITING_ACK, `ack_from_next`=1: set `DOR`<=0, `data_out`<=0, and go to IDLE.
  - WAITING_ACK, no ack: hold `DOR` and `data_out`.
- **Simultaneous push and pop.** Both happen at the same edge, and `count` is unchanged. A push into an empty FIFO is not visible to a pop at the same edge; the pop sees it one edge later.
- **Pointer wrap.** Pointers are log2(DEPTH) bits and wrap naturally. Full and empty are derived from `count`, not from pointer equality.
- **Reset mid-transfer.** Buffered and in-flight bytes are discarded, and no ack is emitted. Upstream must reset concurrently.

## Timing
- Accept latency: DIR high is sampled at edge E. `ack_prev` is high for exactly one cycle, E to E+1.
- Through latency, empty FIFO and idle output: accept at E, pop at E+1. `DOR` and `data_out` are valid after E+1, i.e. 2 cycles after DIR is sampled.
- Downstream turnaround: ack sampled at edge F, so `DOR`=0 during F..F+1. The next byte can present after F+1, giving a minimum DOR low time of 1 cycle.
- Peak throughput is one byte per 2 cycles on each side.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `pipeline_pkg`:
  - parameters `IDLE`/`WAITING_ACK`, shared with the `+1` stage;
  - data width 8;
  - a saturating-double function.
- Sub-module `pipe_fifo`: parameterised depth and width, push/pop/count, with asynchronous active-low reset. It has no handshake logic.
- `stage_B` holds the accept logic, the output FSM and the transform.

## Test plan
- **Single byte.** Reset, then DIR=1 with `data_in`=5, held until ack.
  - `ack_prev` pulses 1 cycle.
  - 2 cycles after DIR is sampled: DOR=1, `data_out`=10.
  - After `ack_from_next` pulses: DOR=0 and `data_out`=0 the next cycle.
- **Saturation.** Inputs 127, 128, 200 → outputs 254, 255, 255 in order.
- **Full / backpressure.** Hold `ack_from_next`=0 and feed 6 bytes 1..6 with DEPTH=4.
  - Byte 1 goes to the output register; bytes 2..5 fill the FIFO (`count`=4).
  - Byte 6 receives no ack while `count` stays 4.
  - After one downstream ack, byte 6 is accepted within 2 cycles.
  - Outputs arrive in order: 2, 4, 6, 8, 10, 12.
- **Wrap and simultaneous push/pop.** Stream 20 bytes with downstream acking every DOR immediately.
  - `count` never exceeds 1.
  - All 20 outputs are correct and in order, exercising pointer wrap 5 times.
- **No double accept.** DIR held high continuously with a fixed value 9.
  - `ack_prev` pattern is 1,0,1,0…
  - Each ack corresponds to exactly one push (verified via `count`).
- **Async reset mid-stream.** Drop `reset` low, off-edge, with `count`=3 and DOR=1.
  - DOR, `data_out`, `ack_prev` and `count` go to 0 immediately, without waiting for a clock edge.
  - After release, the first new byte 7 produces 14.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the byte pipeline: data width, output FSM encoding
// and the saturating-double transform.
`default_nettype none

package pipeline_pkg;

  localparam int DATA_W = 8;

  // Encoding is shared with the +1 stage, so the values are pinned.
  typedef enum logic {
    IDLE        = 1'b0,
    WAITING_ACK = 1'b1
  } state_e;

  function automatic logic [DATA_W-1:0] sat_double(input logic [DATA_W-1:0] d);
    logic [DATA_W:0] wide;
    wide = {d, 1'b0};
    return wide[DATA_W] ? {DATA_W{1'b1}} : wide[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stage_b_if.sv
// Upstream and downstream handshake bundle of stage_b.
`default_nettype none

interface stage_b_if #(
  parameter int DEPTH = 4
) ();

  logic                       DIR;
  logic [7:0]                 data_in;
  logic                       ack_prev;
  logic                       DOR;
  logic [7:0]                 data_out;
  logic                       ack_from_next;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport master (
    output DIR, data_in, ack_from_next,
    input  ack_prev, DOR, data_out, count
  );

  modport slave (
    input  DIR, data_in, ack_from_next,
    output ack_prev, DOR, data_out, count
  );

endinterface

`default_nettype wire

// File: rtl/pipe_fifo.sv
// Plain circular FIFO with push/pop/count; full and empty come from count.
`default_nettype none

module pipe_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] wdata_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] rdata_o,
  output logic      [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stage_b.sv
// Second pipeline stage: buffers upstream bytes in a FIFO and offers each
// byte, doubled with saturation, to the next stage.
`default_nettype none

module stage_b #(
  parameter int DEPTH = 4
) (
  input wire logic  clk,
  input wire logic  reset,
  stage_b_if.slave  bus
);

  import pipeline_pkg::*;

  localparam int            CW   = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_e              state_q, state_d;
  logic                ack_prev_q, ack_prev_d;
  logic                dor_q, dor_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                push;
  logic                pop;
  logic [DATA_W-1:0]   head;
  logic [CW-1:0]       count;

  pipe_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .wdata_i (bus.data_in),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    state_d = state_q;
    dor_d   = dor_q;
    dout_d  = dout_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          dor_d   = 1'b1;
          dout_d  = sat_double(head);
          state_d = WAITING_ACK;
        end else begin
          dor_d  = 1'b0;
          dout_d = '0;
        end
      end
      WAITING_ACK: begin
        if (bus.ack_from_next) begin
          dor_d   = 1'b0;
          dout_d  = '0;
          state_d = IDLE;
        end
      end
    endcase
    // Requiring ack_prev low keeps a still-high DIR from being taken twice.
    push       = bus.DIR && !ack_prev_q && ((count < FULL) || pop);
    ack_prev_d = push;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_prev_q <= 1'b0;
      dor_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_prev_q <= ack_prev_d;
      dor_q      <= dor_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.ack_prev = ack_prev_q;
  assign bus.DOR      = dor_q;
  assign bus.data_out = dout_q;
  assign bus.count    = count;

endmodule

`default_nettype wire

// File: tb/tb_stage_b.sv
// Self-checking bench for stage_b: scoreboard of expected bytes, one task per scenario.
`default_nettype none

module tb_stage_b;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  stage_b_if #(.DEPTH(DEPTH)) bus ();

  stage_b #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] model(input int d);
    int r;
    r = d * 2;
    if (r > 255) return 8'd255;
    return r[7:0];
  endfunction

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    bus.DIR     = 1'b1;
    bus.data_in = d;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack_prev !== 1'b1 && n < 40);
    tests++;
    if (bus.ack_prev !== 1'b1) begin
      fails++;
      $display("FAIL send_ack byte=%0d: ack_prev=%b required 1", d, bus.ack_prev);
    end else begin
      exp_q.push_back(model(d));
    end
    bus.DIR = 1'b0;
  endtask

  task automatic recv(input int delay);
    int n;
    logic [7:0] e;
    n = 0;
    while (bus.DOR !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.DOR !== 1'b1) begin
      fails++;
      $display("FAIL recv_timeout: DOR=%b required 1", bus.DOR);
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL recv_unexpected: data_out=%0d required none", bus.data_out);
    end else begin
      e = exp_q.pop_front();
      if (bus.data_out !== e) begin
        fails++;
        $display("FAIL recv_data: data_out=%0d required %0d", bus.data_out, e);
      end
    end
    repeat (delay) @(negedge clk);
    bus.ack_from_next = 1'b1;
    @(negedge clk);
    bus.ack_from_next = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests += 4;
    if (bus.ack_prev !== 1'b0) begin fails++; $display("FAIL reset_ack: ack_prev=%b required 0", bus.ack_prev); end
    if (bus.DOR !== 1'b0) begin fails++; $display("FAIL reset_dor: DOR=%b required 0", bus.DOR); end
    if (bus.data_out !== 8'd0) begin fails++; $display("FAIL reset_data: data_out=%0d required 0", bus.data_out); end
    if (bus.count !== 3'd0) begin fails++; $display("FAIL reset_count: count=%0d required 0", bus.count); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.DIR     = 1'b1;
    bus.data_in = 8'd5;
    @(negedge clk);
    tests += 2;
    if (bus.ack_prev !== 1'b1) begin fails++; $display("FAIL single_ack: ack_prev=%b required 1", bus.ack_prev); end
    if (bus.DOR !== 1'b0) begin fails++; $display("FAIL single_dor_early: DOR=%b required 0", bus.DOR); end
    bus.DIR = 1'b0;
    @(negedge clk);
    tests += 3;
    if (bus.ack_prev !== 1'b0) begin fails++; $display("FAIL single_ack_pulse: ack_prev=%b required 0", bus.ack_prev); end
    if (bus.DOR !== 1'b1) begin fails++; $display("FAIL single_dor: DOR=%b required 1", bus.DOR); end
    if (bus.data_out !== model(5)) begin fails++; $display("FAIL single_data: data_out=%0d required %0d", bus.data_out, model(5)); end
    bus.ack_from_next = 1'b1;
    @(negedge clk);
    bus.ack_from_next = 1'b0;
    tests += 2;
    if (bus.DOR !== 1'b0) begin fails++; $display("FAIL single_dor_clear: DOR=%b required 0", bus.DOR); end
    if (bus.data_out !== 8'd0) begin fails++; $display("FAIL single_data_clear: data_out=%0d required 0", bus.data_out); end
  endtask

  task automatic test_saturation();
    fork
      begin send(8'd127); send(8'd128); send(8'd200); end
      begin repeat (3) recv(0); end
    join
  endtask

  task automatic test_full();
    int n;
    for (int i = 1; i <= 5; i++) send(i[7:0]);
    tests += 3;
    if (bus.count !== 3'd4) begin fails++; $display("FAIL full_count: count=%0d required 4", bus.count); end
    if (bus.DOR !== 1'b1) begin fails++; $display("FAIL full_dor: DOR=%b required 1", bus.DOR); end
    if (bus.data_out !== exp_q[0]) begin fails++; $display("FAIL full_head: data_out=%0d required %0d", bus.data_out, exp_q[0]); end
    bus.DIR     = 1'b1;
    bus.data_in = 8'd6;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests += 2;
      if (bus.ack_prev !== 1'b0) begin fails++; $display("FAIL full_no_ack: ack_prev=%b required 0", bus.ack_prev); end
      if (bus.count !== 3'd4) begin fails++; $display("FAIL full_hold: count=%0d required 4", bus.count); end
    end
    void'(exp_q.pop_front());
    bus.ack_from_next = 1'b1;
    @(negedge clk);
    bus.ack_from_next = 1'b0;
    n = 1;
    while (bus.ack_prev !== 1'b1 && n < 2) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.ack_prev !== 1'b1) begin
      fails++;
      $display("FAIL full_late_accept: ack_prev=%b required 1", bus.ack_prev);
    end else begin
      exp_q.push_back(model(6));
    end
    bus.DIR = 1'b0;
    repeat (5) recv(0);
  endtask

  task automatic test_wrap();
    int  maxc;
    bit  done;
    maxc = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(8'($urandom_range(0, 255)));
      end
      begin
        repeat (20) recv(0);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          if (int'(bus.count) > maxc) maxc = int'(bus.count);
        end
      end
    join
    tests++;
    if (maxc > 1) begin fails++; $display("FAIL wrap_count: max count=%0d required <=1", maxc); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL wrap_leftover: %0d outputs missing required 0", exp_q.size()); end
  endtask

  task automatic test_no_double();
    int exp_cnt;
    bus.DIR     = 1'b1;
    bus.data_in = 8'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_cnt = (k + 1) / 2 - ((k >= 2) ? 1 : 0);
      tests += 2;
      if (bus.ack_prev !== k[0]) begin fails++; $display("FAIL nodbl_ack cycle %0d: ack_prev=%b required %b", k, bus.ack_prev, k[0]); end
      if (int'(bus.count) != exp_cnt) begin fails++; $display("FAIL nodbl_count cycle %0d: count=%0d required %0d", k, bus.count, exp_cnt); end
      if (k[0]) exp_q.push_back(model(9));
    end
    bus.DIR = 1'b0;
    repeat (5) recv(0);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) send(8'(i + 40));
    tests += 2;
    if (bus.count !== 3'd3) begin fails++; $display("FAIL areset_pre_count: count=%0d required 3", bus.count); end
    if (bus.DOR !== 1'b1) begin fails++; $display("FAIL areset_pre_dor: DOR=%b required 1", bus.DOR); end
    #2;
    reset = 1'b0;
    #1;
    tests += 4;
    if (bus.DOR !== 1'b0) begin fails++; $display("FAIL areset_dor: DOR=%b required 0", bus.DOR); end
    if (bus.data_out !== 8'd0) begin fails++; $display("FAIL areset_data: data_out=%0d required 0", bus.data_out); end
    if (bus.ack_prev !== 1'b0) begin fails++; $display("FAIL areset_ack: ack_prev=%b required 0", bus.ack_prev); end
    if (bus.count !== 3'd0) begin fails++; $display("FAIL areset_count: count=%0d required 0", bus.count); end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    fork
      send(8'd7);
      recv(0);
    join
  endtask

  initial begin
    bus.DIR           = 1'b0;
    bus.data_in       = 8'd0;
    bus.ack_from_next = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_full();
    test_wrap();
    test_no_double();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
